// File: rtl/mem_issue_queue_if.sv
// Dispatch, wakeup, recall and issue signals of the memory issue queue.
// The queue uses the slave modport; the dispatch/wakeup source uses master.
interface mem_issue_queue_if #(
  parameter int unsigned PREG_W = 6,
  parameter int unsigned AL_W   = 5
);
  logic              in_valid    [2];
  logic              in_is_store [2];
  logic [PREG_W-1:0] in_rs1      [2];
  logic [PREG_W-1:0] in_rs2      [2];
  logic              in_rs1_rdy  [2];
  logic              in_rs2_rdy  [2];
  logic [PREG_W-1:0] in_rd       [2];
  logic [31:0]       in_imm      [2];
  logic [AL_W-1:0]   in_al_idx   [2];
  logic              in_ready;

  logic              wk_valid    [2];
  logic [PREG_W-1:0] wk_rd       [2];

  logic              if_recall;
  logic [AL_W-1:0]   new_front;
  logic [AL_W-1:0]   back;

  logic              out_valid    [2];
  logic              out_is_store [2];
  logic [PREG_W-1:0] out_rd       [2];
  logic [31:0]       out_imm      [2];
  logic [AL_W-1:0]   out_al_idx   [2];
  logic [PREG_W-1:0] out_prs      [4];

  modport master (
    output in_valid, in_is_store, in_rs1, in_rs2, in_rs1_rdy, in_rs2_rdy,
           in_rd, in_imm, in_al_idx, wk_valid, wk_rd, if_recall, new_front, back,
    input  in_ready, out_valid, out_is_store, out_rd, out_imm, out_al_idx, out_prs
  );

  modport slave (
    input  in_valid, in_is_store, in_rs1, in_rs2, in_rs1_rdy, in_rs2_rdy,
           in_rd, in_imm, in_al_idx, wk_valid, wk_rd, if_recall, new_front, back,
    output in_ready, out_valid, out_is_store, out_rd, out_imm, out_al_idx, out_prs
  );
endinterface

// File: rtl/mem_issue_queue.sv
// In-order memory issue queue: two-wide dispatch, tag wakeup, two oldest-ready
// issue in program order, and young-suffix squash on recall.
module mem_issue_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PREG_W  = 6,
  parameter int unsigned AL_SIZE = 32,
  parameter int unsigned AL_W    = $clog2(AL_SIZE)
) (
  input logic             clk,
  input logic             reset,
  mem_issue_queue_if.slave q
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              is_store;
    logic [PREG_W-1:0] rs1;
    logic [PREG_W-1:0] rs2;
    logic              rs1_rdy;
    logic              rs2_rdy;
    logic [PREG_W-1:0] rd;
    logic [31:0]       imm;
    logic [AL_W-1:0]   al_idx;
  } entry_t;

  entry_t            ent_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              wk1_hit [DEPTH];
  logic              wk2_hit [DEPTH];
  logic [PTR_W-1:0]  head1;
  logic              iss0;
  logic              iss1;
  logic [CNT_W-1:0]  n_iss;
  logic [CNT_W-1:0]  survivors;
  logic              disp_en;
  logic [CNT_W-1:0]  n_disp;
  logic [PTR_W-1:0]  slot1_idx;
  entry_t            new_ent [2];
  entry_t            e0;
  entry_t            e1;

  function automatic logic wake_match(input logic [PREG_W-1:0] tag,
                                      input logic v0, input logic [PREG_W-1:0] t0,
                                      input logic v1, input logic [PREG_W-1:0] t1);
    return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
  endfunction

  function automatic logic entry_ready(input entry_t e);
    return e.rs1_rdy && (!e.is_store || e.rs2_rdy);
  endfunction

  // Free-slot check uses the count before this cycle's issue.
  assign q.in_ready = (count_q <= CNT_W'(DEPTH - 2));

  // Wakeup match for every stored entry.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wk1_hit[i] = wake_match(ent_q[i].rs1, q.wk_valid[0], q.wk_rd[0], q.wk_valid[1], q.wk_rd[1]);
      wk2_hit[i] = wake_match(ent_q[i].rs2, q.wk_valid[0], q.wk_rd[0], q.wk_valid[1], q.wk_rd[1]);
    end
  end

  // In-order select on stored ready bits.
  always_comb begin
    head1 = head_q + PTR_W'(1);
    e0    = ent_q[head_q];
    e1    = ent_q[head1];
    iss0  = (count_q != '0) && entry_ready(e0);
    iss1  = iss0 && (count_q >= CNT_W'(2)) && entry_ready(e1);
    n_iss = CNT_W'(iss0) + CNT_W'(iss1);
  end

  // Recall: entries whose age offset falls inside [new_front, back) are squashed.
  always_comb begin
    logic [AL_W-1:0]  span;
    logic [AL_W-1:0]  off;
    logic [PTR_W-1:0] idx;
    survivors = '0;
    span      = q.back - q.new_front;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      off = ent_q[idx].al_idx - q.new_front;
      if ((CNT_W'(i) < count_q) && !(off < span)) begin
        survivors = survivors + CNT_W'(1);
      end
    end
  end

  // Dispatch payload, with same-cycle wakeups folded into the ready bits.
  always_comb begin
    disp_en   = q.in_ready && !q.if_recall;
    n_disp    = disp_en ? (CNT_W'(q.in_valid[0]) + CNT_W'(q.in_valid[1])) : '0;
    slot1_idx = tail_q + PTR_W'(q.in_valid[0]);
    for (int unsigned s = 0; s < 2; s++) begin
      new_ent[s].is_store = q.in_is_store[s];
      new_ent[s].rs1      = q.in_rs1[s];
      new_ent[s].rs2      = q.in_rs2[s];
      new_ent[s].rs1_rdy  = q.in_rs1_rdy[s] ||
                            wake_match(q.in_rs1[s], q.wk_valid[0], q.wk_rd[0], q.wk_valid[1], q.wk_rd[1]);
      new_ent[s].rs2_rdy  = q.in_rs2_rdy[s] ||
                            wake_match(q.in_rs2[s], q.wk_valid[0], q.wk_rd[0], q.wk_valid[1], q.wk_rd[1]);
      new_ent[s].rd       = q.in_rd[s];
      new_ent[s].imm      = q.in_imm[s];
      new_ent[s].al_idx   = q.in_al_idx[s];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      for (int unsigned s = 0; s < 2; s++) begin
        q.out_valid[s]    <= 1'b0;
        q.out_is_store[s] <= 1'b0;
        q.out_rd[s]       <= '0;
        q.out_imm[s]      <= '0;
        q.out_al_idx[s]   <= '0;
      end
      for (int unsigned p = 0; p < 4; p++) begin
        q.out_prs[p] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wk1_hit[i]) ent_q[i].rs1_rdy <= 1'b1;
        if (wk2_hit[i]) ent_q[i].rs2_rdy <= 1'b1;
      end
      if (q.if_recall) begin
        tail_q         <= head_q + PTR_W'(survivors);
        count_q        <= survivors;
        q.out_valid[0] <= 1'b0;
        q.out_valid[1] <= 1'b0;
      end else begin
        if (disp_en && q.in_valid[0]) ent_q[tail_q]    <= new_ent[0];
        if (disp_en && q.in_valid[1]) ent_q[slot1_idx] <= new_ent[1];
        head_q  <= head_q + PTR_W'(n_iss);
        tail_q  <= tail_q + PTR_W'(n_disp);
        count_q <= count_q + n_disp - n_iss;

        q.out_valid[0]    <= iss0;
        q.out_is_store[0] <= iss0 && e0.is_store;
        q.out_rd[0]       <= iss0 ? e0.rd     : '0;
        q.out_imm[0]      <= iss0 ? e0.imm    : '0;
        q.out_al_idx[0]   <= iss0 ? e0.al_idx : '0;
        q.out_prs[0]      <= iss0 ? e0.rs1    : '0;
        q.out_prs[1]      <= iss0 ? e0.rs2    : '0;

        q.out_valid[1]    <= iss1;
        q.out_is_store[1] <= iss1 && e1.is_store;
        q.out_rd[1]       <= iss1 ? e1.rd     : '0;
        q.out_imm[1]      <= iss1 ? e1.imm    : '0;
        q.out_al_idx[1]   <= iss1 ? e1.al_idx : '0;
        q.out_prs[2]      <= iss1 ? e1.rs1    : '0;
        q.out_prs[3]      <= iss1 ? e1.rs2    : '0;
      end
    end
  end

endmodule
